// File: rtl/apb_master.sv
// APB requester: takes one command at a time and runs a SETUP/ACCESS transfer on the timer port.
// Reports read data and an error flag; aborts transfers whose slave never raises pready.
module apb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  // A zero TIMEOUT still needs a one-bit counter to keep the declarations legal.
  localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic                pwrite_reg;
  logic [ADDR_W-1:0]   paddr_reg;
  logic [DATA_W-1:0]   pwdata_reg;
  logic [STRB_W-1:0]   pstrb_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_err_reg;

  logic accept;
  logic done;
  logic abort;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        accept = cmd_valid;
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (tim_pready) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT))) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wait_cnt_reg  <= '0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= done | abort;
      if (accept) begin
        pwrite_reg <= cmd_write;
        paddr_reg  <= cmd_addr;
        pwdata_reg <= cmd_wdata;
        pstrb_reg  <= cmd_write ? cmd_strb : '0;
      end
      if (state_reg == SETUP) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == ACCESS && !tim_pready) begin
        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
      end
      if (done) begin
        rsp_err_reg <= tim_pslverr;
        if (!pwrite_reg) rsp_rdata_reg <= tim_prdata;
      end else if (abort) begin
        rsp_err_reg   <= 1'b1;
        rsp_rdata_reg <= '0;
      end
    end
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign tim_psel    = (state_reg != IDLE);
  assign tim_penable = (state_reg == ACCESS);
  assign tim_pwrite  = pwrite_reg;
  assign tim_paddr   = paddr_reg;
  assign tim_pwdata  = pwdata_reg;
  assign tim_pstrb   = pstrb_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a scripted APB slave plus a transaction-level model of
// response timing, read data, error and timeout outcomes.
module tb_apb_master;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [11:0]       cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_strb = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              tim_psel;
  logic              tim_penable;
  logic              tim_pwrite;
  logic [11:0]       tim_paddr;
  logic [31:0]       tim_pwdata;
  logic [3:0]        tim_pstrb;
  logic              tim_pready = 1'b0;
  logic [31:0]       tim_prdata = '0;
  logic              tim_pslverr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rdata = '0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_pready(tim_pready), .tim_prdata(tim_prdata), .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One complete transfer. The slave holds pready low for 'waits' ACCESS cycles and then
  // answers with rd/se; more waits than TIMEOUT means the master must give up.
  task automatic do_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input int waits, input logic [31:0] rd,
                         input logic se);
    bit          is_abort;
    int          n_acc;
    logic [3:0]  exp_strb;
    logic        exp_err;
    is_abort = (waits > TIMEOUT);
    n_acc    = is_abort ? TIMEOUT + 1 : waits + 1;
    exp_strb = wr ? st : 4'h0;
    @(negedge sys_clk);
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st;
    @(negedge sys_clk);
    cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_strb = $urandom;
    check("setup_psel", tim_psel, 1);
    check("setup_penable", tim_penable, 0);
    check("setup_ready", cmd_ready, 0);
    check("setup_paddr", tim_paddr, a);
    check("setup_pwrite", tim_pwrite, wr);
    check("setup_pwdata", tim_pwdata, wd);
    check("setup_pstrb", tim_pstrb, exp_strb);
    for (int k = 0; k < n_acc; k++) begin
      @(negedge sys_clk);
      check("acc_psel", tim_psel, 1);
      check("acc_penable", tim_penable, 1);
      check("acc_rsp_valid", rsp_valid, 0);
      check("acc_paddr", tim_paddr, a);
      check("acc_pwdata", tim_pwdata, wd);
      check("acc_pstrb", tim_pstrb, exp_strb);
      if (k == waits) begin
        tim_pready = 1'b1; tim_prdata = rd; tim_pslverr = se;
      end else begin
        tim_pready = 1'b0; tim_prdata = $urandom; tim_pslverr = $urandom;
      end
    end
    @(negedge sys_clk);
    tim_pready = 1'b0;
    if (is_abort) begin
      exp_err = 1'b1;
      last_rdata = 32'h0;
    end else begin
      exp_err = se;
      if (!wr) last_rdata = rd;
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, last_rdata);
    check("done_psel", tim_psel, 0);
    check("done_penable", tim_penable, 0);
    check("done_ready", cmd_ready, 1);
    check("idle_paddr_held", tim_paddr, a);
    @(negedge sys_clk);
    check("rsp_pulse_end", rsp_valid, 0);
    check("rsp_rdata_held", rsp_rdata, last_rdata);
    $display("[TB] %s addr=0x%03h wdata=0x%08h strb=0x%0h waits=%0d -> err=%0b rdata=0x%08h",
             wr ? "WR" : "RD", a, wd, st, waits, rsp_err, rsp_rdata);
  endtask

  logic exp_psel_seq [7] = '{0, 1, 1, 0, 1, 1, 0};
  logic exp_rsp_seq  [7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    // Reset state, with a command offered that must be discarded.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'hFFF;
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_psel", tim_psel, 0);
    check("rst_penable", tim_penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_paddr", tim_paddr, 0);
    check("rst_pstrb", tim_pstrb, 0);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Directed: write with one wait, read returning 0xA5, timeout, slave error then clean.
    do_xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 1, 32'h0, 1'b0);
    do_xfer(1'b0, 12'h010, 32'h12345678, 4'hF, 0, 32'h000000A5, 1'b0);
    do_xfer(1'b0, 12'h020, 32'h0, 4'h0, TIMEOUT + 4, 32'hCAFEF00D, 1'b0);
    do_xfer(1'b1, 12'h00C, 32'h55AA55AA, 4'h3, TIMEOUT, 32'h0, 1'b1);
    do_xfer(1'b1, 12'h00C, 32'hA5A5A5A5, 4'hC, 0, 32'h0, 1'b0);

    // Back-to-back with pready tied high: responses 3 cycles apart.
    @(negedge sys_clk);
    tim_pready = 1'b1; tim_pslverr = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030; cmd_wdata = 32'h1; cmd_strb = 4'hF;
    for (int t = 0; t < 7; t++) begin
      if (t > 0) @(negedge sys_clk);
      check("b2b_psel", tim_psel, exp_psel_seq[t]);
      check("b2b_rsp_valid", rsp_valid, exp_rsp_seq[t]);
      if (exp_rsp_seq[t]) check("b2b_rsp_err", rsp_err, 0);
      if (t == 4) cmd_valid = 1'b0;
    end
    $display("[TB] B2B two writes, responses at T3 and T6");
    tim_pready = 1'b0;

    // Reset during ACCESS: outputs drop at once and no response follows.
    @(negedge sys_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h040; cmd_wdata = 32'h77; cmd_strb = 4'hF;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("pre_rst_penable", tim_penable, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midrst_psel", tim_psel, 0);
    check("midrst_penable", tim_penable, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    @(negedge sys_clk);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    sys_rst_n = 1'b1;
    last_rdata = 32'h0;
    for (int t = 0; t < 3; t++) begin
      @(negedge sys_clk);
      check("postrst_rsp_valid", rsp_valid, 0);
      check("postrst_psel", tim_psel, 0);
    end
    $display("[TB] RST during ACCESS, transfer dropped");
    do_xfer(1'b1, 12'h008, 32'h0BADF00D, 4'hF, 2, 32'h0, 1'b0);

    // Random transfers, occasionally long enough to time out.
    for (int i = 0; i < 40; i++) begin
      int w;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                      : $urandom_range(0, 3);
      do_xfer(1'($urandom), 12'($urandom), $urandom, 4'($urandom), w, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
